// File: rtl/button_reader.sv
// Active-low pushbutton/DIP front end: two-flop synchronizer, tick-based debouncer,
// press/release strobes and a lowest-index key encoder.
module button_reader #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TICK_DIV  = 13300,
  parameter int unsigned DEB_TICKS = 100,
  parameter int unsigned CODE_W    = 3
) (
  input  logic              osc_clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  btn_n,
  output logic [WIDTH-1:0]  btn_state,
  output logic [WIDTH-1:0]  btn_press,
  output logic [WIDTH-1:0]  btn_release,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              any_pressed
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(DEB_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

  logic [WIDTH-1:0]  sync1_q, sync2_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [CW-1:0]     cnt_q [WIDTH];
  logic [CW-1:0]     cnt_d [WIDTH];
  logic [WIDTH-1:0]  state_q, state_d;
  logic [WIDTH-1:0]  press_q, press_d;
  logic [WIDTH-1:0]  release_q, release_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              any_q;
  logic              found;

  assign tick    = (presc_q == PRE_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Any cycle where the synchronized pin agrees with the accepted level restarts the count.
  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i]   = sync2_q[i];
          cnt_d[i]     = '0;
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    code_d  = code_q;
    valid_d = 1'b0;
    found   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && press_q[i]) begin
        found   = 1'b1;
        code_d  = CODE_W'(i);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= '0;
      cnt_q     <= '{default: '0};
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      sync1_q   <= ~btn_n;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      any_q     <= |state_q;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign any_pressed = any_q;

endmodule

// File: tb/tb_button_reader.sv
// Randomized bench for button_reader; outputs compared every cycle against an
// interval-based reference model (ticks counted arithmetically over each mismatch run).
module tb_button_reader;

  localparam int TD  = 4;
  localparam int DEB = 3;

  logic       osc_clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn_n;
  logic [7:0] btn_state, btn_press, btn_release;
  logic [2:0] key_code;
  logic       key_valid, any_pressed;

  int n_checks = 0;
  int n_pass   = 0;

  button_reader #(
    .WIDTH(8),
    .TICK_DIV(TD),
    .DEB_TICKS(DEB),
    .CODE_W(3)
  ) dut (
    .osc_clk    (osc_clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .any_pressed(any_pressed)
  );

  always #5 osc_clk = ~osc_clk;

  // Reference model state
  int         p_cnt = 0;
  int         run_a [8];
  logic [7:0] ms1 = '0, ms2 = '0, mst = '0, mpr = '0, mrl = '0;
  logic [2:0] mcode = '0;
  logic       mkv = 1'b0, many = 1'b0;

  initial for (int i = 0; i < 8; i++) run_a[i] = -1;

  // P counts non-reset edges since the last reset; a tick happens in cycle P when P%TD==TD-1.
  always @(posedge osc_clk) begin
    logic [7:0] st_n, pr_n, rl_n;
    int nt;
    if (!rst_n) begin
      ms1 = '0; ms2 = '0; mst = '0; mpr = '0; mrl = '0;
      mcode = '0; mkv = 1'b0; many = 1'b0; p_cnt = 0;
      for (int i = 0; i < 8; i++) run_a[i] = -1;
    end else begin
      st_n = mst; pr_n = '0; rl_n = '0;
      for (int i = 0; i < 8; i++) begin
        if (ms2[i] !== mst[i]) begin
          if (run_a[i] < 0) run_a[i] = p_cnt;
          nt = (p_cnt + 1) / TD - run_a[i] / TD;
          if (nt >= DEB) begin
            st_n[i] = ms2[i];
            pr_n[i] = ms2[i];
            rl_n[i] = ~ms2[i];
            run_a[i] = -1;
          end
        end else begin
          run_a[i] = -1;
        end
      end
      if (mpr != 8'h00) begin
        mkv = 1'b1;
        for (int i = 7; i >= 0; i--) if (mpr[i]) mcode = 3'(i);
      end else begin
        mkv = 1'b0;
      end
      many = |mst;
      mst = st_n; mpr = pr_n; mrl = rl_n;
      ms2 = ms1; ms1 = ~btn_n;
      p_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge osc_clk);
      check("btn_state",   32'(btn_state),   32'(mst));
      check("btn_press",   32'(btn_press),   32'(mpr));
      check("btn_release", 32'(btn_release), 32'(mrl));
      check("key_code",    32'(key_code),    32'(mcode));
      check("key_valid",   32'(key_valid),   32'(mkv));
      check("any_pressed", 32'(any_pressed), 32'(many));
    end
  endtask

  initial begin
    logic [7:0] flip;
    rst_n = 1'b0;
    btn_n = 8'h00;
    cyc(3);
    rst_n = 1'b1;
    cyc(25);
    btn_n = 8'hFF;
    cyc(25);
    // clean press of bit 5
    btn_n[5] = 1'b0;
    cyc(25);
    // bounce on bit 2, shorter than the debounce interval
    for (int k = 0; k < 10; k++) begin
      btn_n[2] = ~btn_n[2];
      cyc(6);
    end
    btn_n[2] = 1'b1;
    cyc(25);
    // simultaneous press of bits 6 and 3
    btn_n[6] = 1'b0;
    btn_n[3] = 1'b0;
    cyc(25);
    btn_n[5] = 1'b1;
    cyc(25);
    btn_n = 8'hFF;
    cyc(25);
    // reset in the middle of a pending press
    btn_n[1] = 1'b0;
    cyc(10);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(25);
    // randomized phases with occasional reset
    for (int ph = 0; ph < 300; ph++) begin
      rst_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      flip  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) flip = 8'(1 << $urandom_range(0, 7));
      btn_n = btn_n ^ flip;
      cyc(($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 8));
    end
    rst_n = 1'b1;
    cyc(30);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
